// File: rtl/modexp_ctrl.sv
// Modular-exponentiation controller: loads 32-word operands, walks the
// exponent MSB-first issuing Montgomery operations (left-to-right binary
// method), then streams the 32-word result out of the datapath.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   startInput           load request (IDLE only)
//   m/n/e_input          operand words, LS word first (m/n go to datapath)
//   ld_we, ld_addr       datapath m/n write strobe and word address
//   mm_start, mm_op      multiplier start pulse and operation code
//   mm_done              multiplier completion pulse
//   getResult            readout request (DONE only)
//   res_addr, res_in     result read address / data (data one cycle later)
//   res_out, res_valid   registered result word and qualifier
//   busy, state          status / debug
module modexp_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startInput,
  input  logic [DATA_WIDTH-1:0] m_input,
  input  logic [DATA_WIDTH-1:0] n_input,
  input  logic [DATA_WIDTH-1:0] e_input,
  input  logic                  getResult,
  output logic                  ld_we,
  output logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  mm_start,
  output logic [2:0]            mm_op,
  input  logic                  mm_done,
  output logic [ADDR_WIDTH-1:0] res_addr,
  input  logic [DATA_WIDTH-1:0] res_in,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic                  res_valid,
  output logic                  busy,
  output logic [3:0]            state
);

  localparam int unsigned TOTAL_ADDR = 2 ** ADDR_WIDTH;
  localparam int unsigned BIT_W      = $clog2(DATA_WIDTH);
  localparam int unsigned IDX_W      = ADDR_WIDTH + BIT_W;
  localparam logic [IDX_W-1:0]      IDX_MAX  = {IDX_W{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  localparam logic [2:0] OP_CONV_M   = 3'd0;
  localparam logic [2:0] OP_CONV_X   = 3'd1;
  localparam logic [2:0] OP_SQUARE   = 3'd2;
  localparam logic [2:0] OP_MULT     = 3'd3;
  localparam logic [2:0] OP_CONV_OUT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_CONV_M   = 4'd2,
    S_CONV_X   = 4'd3,
    S_SCAN     = 4'd4,
    S_SQUARE   = 4'd5,
    S_MULT     = 4'd6,
    S_CONV_OUT = 4'd7,
    S_DONE     = 4'd8,
    S_READ     = 4'd9
  } state_t;

  state_t                  state_q, state_d;
  logic                    ld_we_q, ld_we_d;
  logic [ADDR_WIDTH-1:0]   ld_addr_q, ld_addr_d;
  logic                    mm_start_q, mm_start_d;
  logic [2:0]              mm_op_q, mm_op_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic                    addr_act_q, addr_act_d;   // res_addr valid this cycle
  logic                    rd_pend_q, rd_pend_d;     // res_in valid this cycle
  logic [DATA_WIDTH-1:0]   res_out_q, res_out_d;
  logic                    res_valid_q, res_valid_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   bank_q [TOTAL_ADDR];
  logic                    exp_bit;
  logic                    mm_ack;

  // m/n words are written straight into the datapath; only e is kept here.
  logic unused_operands;
  assign unused_operands = ^{m_input, n_input};

  assign exp_bit = bank_q[idx_q[IDX_W-1:BIT_W]][idx_q[BIT_W-1:0]];
  // A done pulse coinciding with our own start pulse is stale.
  assign mm_ack  = mm_done & ~mm_start_q;

  // Exponent bank, written during LOAD.
  always_ff @(posedge clk) begin
    if (ld_we_q) bank_q[ld_addr_q] <= e_input;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      mm_start_q  <= 1'b0;
      mm_op_q     <= 3'd0;
      idx_q       <= IDX_MAX;
      res_addr_q  <= '0;
      addr_act_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      mm_start_q  <= mm_start_d;
      mm_op_q     <= mm_op_d;
      idx_q       <= idx_d;
      res_addr_q  <= res_addr_d;
      addr_act_q  <= addr_act_d;
      rd_pend_q   <= rd_pend_d;
      res_out_q   <= res_out_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and registered-output logic; every issue-state entry
  // (including SQUARE re-entry) raises mm_start for one cycle.
  always_comb begin
    state_d     = state_q;
    ld_we_d     = 1'b0;
    ld_addr_d   = '0;
    mm_start_d  = 1'b0;
    mm_op_d     = mm_op_q;
    idx_d       = idx_q;
    res_addr_d  = res_addr_q;
    addr_act_d  = 1'b0;
    rd_pend_d   = addr_act_q;
    res_valid_d = rd_pend_q;
    res_out_d   = rd_pend_q ? res_in : res_out_q;

    case (state_q)
      S_IDLE: begin
        if (startInput) begin
          state_d = S_LOAD;
          ld_we_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (ld_addr_q == ADDR_MAX) begin
          state_d    = S_CONV_M;
          mm_start_d = 1'b1;
          mm_op_d    = OP_CONV_M;
        end else begin
          ld_we_d   = 1'b1;
          ld_addr_d = ld_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_CONV_M: begin
        if (mm_ack) begin
          state_d    = S_CONV_X;
          mm_start_d = 1'b1;
          mm_op_d    = OP_CONV_X;
        end
      end
      S_CONV_X: begin
        if (mm_ack) begin
          state_d = S_SCAN;
          idx_d   = IDX_MAX;
        end
      end
      // Skip leading zero bits without touching the multiplier.
      S_SCAN: begin
        if (exp_bit) begin
          state_d    = S_SQUARE;
          mm_start_d = 1'b1;
          mm_op_d    = OP_SQUARE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          state_d    = S_CONV_OUT;
          mm_start_d = 1'b1;
          mm_op_d    = OP_CONV_OUT;
        end
      end
      S_SQUARE: begin
        if (mm_ack) begin
          mm_start_d = 1'b1;
          if (exp_bit) begin
            state_d = S_MULT;
            mm_op_d = OP_MULT;
          end else if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SQUARE;
            mm_op_d = OP_SQUARE;
          end else begin
            state_d = S_CONV_OUT;
            mm_op_d = OP_CONV_OUT;
          end
        end
      end
      S_MULT: begin
        if (mm_ack) begin
          mm_start_d = 1'b1;
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SQUARE;
            mm_op_d = OP_SQUARE;
          end else begin
            state_d = S_CONV_OUT;
            mm_op_d = OP_CONV_OUT;
          end
        end
      end
      S_CONV_OUT: begin
        if (mm_ack) state_d = S_DONE;
      end
      S_DONE: begin
        if (getResult) begin
          state_d    = S_READ;
          res_addr_d = '0;
          addr_act_d = 1'b1;
        end
      end
      // Addresses run 0..31, then the two-deep data pipe drains.
      S_READ: begin
        if (addr_act_q && (res_addr_q != ADDR_MAX)) begin
          addr_act_d = 1'b1;
          res_addr_d = res_addr_q + ADDR_WIDTH'(1);
        end else if (!addr_act_q && !rd_pend_q && res_valid_q) begin
          state_d    = S_IDLE;
          res_addr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ld_we     = ld_we_q;
  assign ld_addr   = ld_addr_q;
  assign mm_start  = mm_start_q;
  assign mm_op     = mm_op_q;
  assign res_addr  = res_addr_q;
  assign res_out   = res_out_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a 3-cycle multiplier model, a
// registered-read result datapath model, and scoreboards for the expected
// multiplier op sequence and result words.
module tb_modexp_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NW = 32;

  localparam logic [2:0] CM = 3'd0, CX = 3'd1, SQ = 3'd2, MU = 3'd3, CO = 3'd4;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_CONV_M = 4'd2, ST_SCAN = 4'd4,
                         ST_SQUARE = 4'd5, ST_DONE = 4'd8, ST_READ = 4'd9;

  logic clk = 1'b0;
  logic reset, startInput, getResult, mm_done;
  logic [DW-1:0] m_input, n_input, e_input, res_out;
  logic [DW-1:0] res_in = '0;
  logic ld_we, mm_start, res_valid, busy;
  logic [AW-1:0] ld_addr, res_addr;
  logic [AW-1:0] prev_addr = '0;
  logic [2:0] mm_op;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_scan = 0, n_beats = 0, done_cnt = 0;
  logic model_done = 1'b0;
  logic inj_done = 1'b0;
  logic [2:0]    exp_ops[$];
  logic [DW-1:0] exp_res[$];

  assign mm_done = model_done | inj_done;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .startInput(startInput),
    .m_input(m_input), .n_input(n_input), .e_input(e_input),
    .getResult(getResult), .ld_we(ld_we), .ld_addr(ld_addr),
    .mm_start(mm_start), .mm_op(mm_op), .mm_done(mm_done),
    .res_addr(res_addr), .res_in(res_in), .res_out(res_out),
    .res_valid(res_valid), .busy(busy), .state(state)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {3'b000, a, 8'hA5, 3'b111, ~a, 8'h3C};
  endfunction

  // Models and output monitors, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [2:0]    eop;
    logic [DW-1:0] eres;
    #1;
    model_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) model_done = 1'b1;
    end
    if (state == ST_SCAN) n_scan++;
    tests++;
    assert ((32'(ld_we) + 32'(mm_start) + 32'(res_valid)) <= 1) else begin
      fails++;
      $error("FAIL strobe_exclusive: ld_we=%0b mm_start=%0b res_valid=%0b, want at most one", ld_we, mm_start, res_valid);
    end
    if (mm_start) begin
      done_cnt = 3;
      n_start++;
      tests++;
      assert (exp_ops.size() != 0) else begin
        fails++;
        $error("FAIL mm_op_unexpected: got pulse op=%0d, want no pulse", mm_op);
      end
      if (exp_ops.size() != 0) begin
        eop = exp_ops.pop_front();
        tests++;
        assert (mm_op === eop) else begin
          fails++;
          $error("FAIL mm_op_seq: got %0d, want %0d (pulse %0d)", mm_op, eop, n_start);
        end
      end
    end
    if (res_valid) begin
      n_beats++;
      tests++;
      assert (exp_res.size() != 0) else begin
        fails++;
        $error("FAIL res_beat_unexpected: got %h, want no beat", res_out);
      end
      if (exp_res.size() != 0) begin
        eres = exp_res.pop_front();
        tests++;
        assert (res_out === eres) else begin
          fails++;
          $error("FAIL res_out_beat%0d: got %h, want %h", n_beats - 1, res_out, eres);
        end
      end
    end
    // Registered-read datapath: data for an address appears one cycle later.
    res_in    = pat(prev_addr);
    prev_addr = res_addr;
  end

  task automatic check_idle(input string tag);
    logic [66+2*AW:0] v;
    v = {state, busy, ld_we, mm_start, mm_op, ld_addr, res_addr, res_out, res_valid};
    tests++;
    assert (v === '0) else begin
      fails++;
      $error("FAIL %s: got state=%0d busy=%0b ld_we=%0b mm_start=%0b mm_op=%0d ld_addr=%0d res_addr=%0d res_out=%h res_valid=%0b, want all zero",
             tag, state, busy, ld_we, mm_start, mm_op, ld_addr, res_addr, res_out, res_valid);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int c;
    c = 0;
    while (state !== s && c < budget) begin
      @(negedge clk);
      c++;
    end
    tests++;
    assert (state === s) else begin
      fails++;
      $error("FAIL %s: state=%0d after %0d cycles, want %0d", tag, state, c, s);
    end
  endtask

  task automatic load_op(input logic [DW-1:0] e0, input logic [DW-1:0] e31);
    @(negedge clk);
    startInput = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(NW); i++) begin
      e_input    = (i == 0) ? e0 : ((i == 31) ? e31 : '0);
      n_input    = (i == 0) ? 32'h8B9496E5 : $urandom;
      m_input    = $urandom;
      startInput = (i == 5 || i == 20);
      tests++;
      assert (ld_we === 1'b1 && ld_addr === AW'(i)) else begin
        fails++;
        $error("FAIL load_beat%0d: ld_we=%0b ld_addr=%0d, want 1/%0d", i, ld_we, ld_addr, i);
      end
      @(negedge clk);
    end
    startInput = 1'b0;
    tests++;
    assert (state === ST_CONV_M && ld_we === 1'b0) else begin
      fails++;
      $error("FAIL load_exit: state=%0d ld_we=%0b, want %0d/0", state, ld_we, ST_CONV_M);
    end
  endtask

  task automatic check_counts(input string tag, input int starts, input int scans);
    tests++;
    assert (n_start == starts && n_scan == scans && exp_ops.size() == 0) else begin
      fails++;
      $error("FAIL %s: pulses=%0d scan=%0d ops_left=%0d, want %0d/%0d/0",
             tag, n_start, n_scan, exp_ops.size(), starts, scans);
    end
  endtask

  task automatic readout(input string tag);
    n_beats = 0;
    for (int i = 0; i < int'(NW); i++) exp_res.push_back(pat(AW'(i)));
    @(negedge clk);
    getResult = 1'b1;
    @(negedge clk);
    getResult = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (n_beats >= 32) break;
    end
    tests++;
    assert (n_beats == 32 && busy === 1'b1 && state === ST_READ) else begin
      fails++;
      $error("FAIL %s_last_beat: beats=%0d busy=%0b state=%0d, want 32/1/%0d", tag, n_beats, busy, state, ST_READ);
    end
    @(negedge clk);
    tests++;
    assert (busy === 1'b0 && state === ST_IDLE && res_valid === 1'b0 && exp_res.size() == 0) else begin
      fails++;
      $error("FAIL %s_end: busy=%0b state=%0d res_valid=%0b left=%0d, want 0/0/0/0", tag, busy, state, res_valid, exp_res.size());
    end
    // getResult in IDLE must be ignored.
    getResult = 1'b1;
    @(negedge clk);
    getResult = 1'b0;
    @(negedge clk);
    tests++;
    assert (state === ST_IDLE && busy === 1'b0 && res_valid === 1'b0) else begin
      fails++;
      $error("FAIL %s_getresult_idle: state=%0d busy=%0b, want 0/0", tag, state, busy);
    end
  endtask

  task automatic push_top_bit_ops();
    exp_ops.push_back(CM);
    exp_ops.push_back(CX);
    exp_ops.push_back(SQ);
    exp_ops.push_back(MU);
    for (int i = 0; i < 1023; i++) exp_ops.push_back(SQ);
    exp_ops.push_back(CO);
  endtask

  initial begin
    reset = 1'b1; startInput = 1'b0; getResult = 1'b0;
    m_input = '0; n_input = '0; e_input = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;

    // e = 0, with stray mm_done/getResult/startInput injected during SCAN.
    n_start = 0; n_scan = 0;
    exp_ops.push_back(CM); exp_ops.push_back(CX); exp_ops.push_back(CO);
    load_op('0, '0);
    wait_state(ST_SCAN, 100, "e0_reach_scan");
    inj_done = 1'b1; getResult = 1'b1; startInput = 1'b1;
    @(negedge clk);
    inj_done = 1'b0; getResult = 1'b0; startInput = 1'b0;
    tests++;
    assert (state === ST_SCAN && mm_start === 1'b0) else begin
      fails++;
      $error("FAIL scan_stray_inputs: state=%0d mm_start=%0b, want %0d/0", state, mm_start, ST_SCAN);
    end
    wait_state(ST_DONE, 20000, "e0_reach_done");
    check_counts("e0_counts", 3, 1024);
    repeat (5) @(negedge clk);
    tests++;
    assert (state === ST_DONE && busy === 1'b1) else begin
      fails++;
      $error("FAIL done_hold: state=%0d busy=%0b, want %0d/1", state, busy, ST_DONE);
    end
    readout("e0_read");

    // Only bit 0 set.
    n_start = 0; n_scan = 0;
    exp_ops.push_back(CM); exp_ops.push_back(CX); exp_ops.push_back(SQ);
    exp_ops.push_back(MU); exp_ops.push_back(CO);
    load_op(32'h0000_0001, '0);
    wait_state(ST_DONE, 20000, "bit0_reach_done");
    check_counts("bit0_counts", 5, 1024);
    readout("bit0_read");

    // Only bit 1023 set: abort with reset during SQUARE first.
    push_top_bit_ops();
    load_op('0, 32'h8000_0000);
    wait_state(ST_SQUARE, 100, "abort_reach_square");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_square");
    reset = 1'b0;
    exp_ops.delete();
    repeat (6) @(negedge clk);
    tests++;
    assert (state === ST_IDLE && busy === 1'b0 && mm_start === 1'b0) else begin
      fails++;
      $error("FAIL late_done_ignored: state=%0d busy=%0b mm_start=%0b, want 0/0/0", state, busy, mm_start);
    end

    n_start = 0; n_scan = 0;
    push_top_bit_ops();
    load_op('0, 32'h8000_0000);
    wait_state(ST_DONE, 20000, "top_reach_done");
    check_counts("top_counts", 1028, 1);
    readout("top_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of all operand/result buses.
REQ-002 Parameter ADDR_WIDTH, default 5, word address width; TOTAL_ADDR = 2**ADDR_WIDTH = 32 words per 1024-bit operand.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 startInput  input  1  load request, sampled in IDLE only.
REQ-006 m_input, n_input, e_input  input  DATA_WIDTH each  operand words, least-significant word first.
REQ-007 getResult  input  1  result readout request, sampled in DONE only.
REQ-008 ld_we  output  1  datapath write enable for m/n words.
REQ-009 ld_addr  output  ADDR_WIDTH  datapath m/n word address.
REQ-010 mm_start  output  1  one-cycle start pulse to Montgomery multiplier (MonPro).
REQ-011 mm_op  output  3  operation: 0 CONV_M (Mbar=MonPro(M,R2)), 1 CONV_X (X=MonPro(1,R2)), 2 SQUARE (X=MonPro(X,X)), 3 MULT (X=MonPro(X,Mbar)), 4 CONV_OUT (X=MonPro(X,1)).
REQ-012 mm_done  input  1  one-cycle completion pulse from multiplier.
REQ-013 res_addr  output  ADDR_WIDTH  result word read address to datapath.
REQ-014 res_in  input  DATA_WIDTH  result word from datapath, valid one cycle after res_addr.
REQ-015 res_out  output  DATA_WIDTH  registered result word.
REQ-016 res_valid  output  1  res_out qualifier.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 state  output  4  current FSM state encoding (debug).

Function
REQ-019 States: IDLE=0, LOAD=1, CONV_M=2, CONV_X=3, SCAN=4, SQUARE=5, MULT=6, CONV_OUT=7, DONE=8, READ=9.
REQ-020 IDLE: startInput=1 -> LOAD; word 0 is present the cycle after startInput is sampled.
REQ-021 LOAD: 32 cycles; ld_we=1, ld_addr=0..31; e_input stored in internal 32x32 exponent bank at same address; after addr 31 -> CONV_M.
REQ-022 Issue states (CONV_M, CONV_X, SQUARE, MULT, CONV_OUT): mm_start=1 for exactly the first cycle in the state, mm_op held constant for the whole state; advance only on mm_done.
REQ-023 mm_done outside an issue state, or in the same cycle as mm_start, is ignored.
REQ-024 CONV_M done -> CONV_X; CONV_X done -> SCAN with 10-bit bit index idx=1023.
REQ-025 Exponent bit = bank[idx[9:5]][idx[4:0]].
REQ-026 SCAN: one bit per cycle; bit=1 -> SQUARE; bit=0 and idx>0 -> idx-1; bit=0 and idx=0 -> CONV_OUT (e=0).
REQ-027 SQUARE done: bit(idx)=1 -> MULT; else idx>0 -> idx-1, SQUARE; else CONV_OUT.
REQ-028 MULT done: idx>0 -> idx-1, SQUARE; idx=0 -> CONV_OUT.
REQ-029 After the first 1 bit, no further scanning: every lower bit costs exactly one SQUARE plus one MULT if set.
REQ-030 CONV_OUT done -> DONE; DONE holds until getResult=1 -> READ.
REQ-031 READ: res_addr=0..31 over 32 cycles; res_out<=res_in and res_valid=1 one cycle after each address; 32 valid beats total, then IDLE.
REQ-032 startInput outside IDLE and getResult outside DONE are ignored.
REQ-033 ld_we, mm_start, res_valid are never asserted in the same cycle.

Reset
REQ-034 reset=1 at any clock edge, including mid-operation: state=IDLE, busy=0, ld_we=0, mm_start=0, mm_op=0, ld_addr=0, res_addr=0, res_out=0, res_valid=0, idx=1023; exponent bank contents undefined.
REQ-035 A multiplier mm_done arriving after reset is ignored per REQ-023.

Verification
REQ-036 e=all zero -> mm_op sequence CONV_M, CONV_X, CONV_OUT; 3 mm_start pulses; 1024 SCAN cycles.
REQ-037 e word0=0x00000001, rest 0 -> 1023 SCAN-advance cycles, then CONV_M..: ops CONV_M, CONV_X, SQUARE, MULT, CONV_OUT; 5 pulses.
REQ-038 e word31=0x80000000, rest 0 -> 1028 mm_start pulses: CONV_M, CONV_X, SQUARE, MULT, 1023 SQUARE, CONV_OUT.
REQ-039 Load 32 words (n word0=0x8B9496E5) -> ld_addr 0..31 with ld_we high 32 cycles; startInput pulses during load ignored.
REQ-040 Multiplier model returning mm_done after 3 cycles; extra mm_done injected in SCAN -> no state change; reset asserted in SQUARE -> IDLE next cycle, all outputs zero.
REQ-041 DONE then getResult=1 with res_in=addr-tagged pattern -> 32 res_valid beats, res_out matches address 0..31 in order, busy drops after last beat.
